// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM encoding, frame geometry and the microsecond-to-cycle helper.
package ps2_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_INHIBIT  = 3'd1;
  localparam logic [2:0] ST_REQ      = 3'd2;
  localparam logic [2:0] ST_BITS     = 3'd3;
  localparam logic [2:0] ST_ACK      = 3'd4;
  localparam logic [2:0] ST_WAITIDLE = 3'd5;
  localparam logic [2:0] ST_DONE     = 3'd6;
  localparam logic [2:0] ST_ERROR    = 3'd7;

  // Data bits, parity and stop; the device ACK arrives on the clock after.
  localparam int FRAME_BITS = 10;
  localparam int ACK_FALL   = 11;

  // 64-bit intermediate so long timeouts at high clock rates do not overflow.
  function automatic int us2cyc(input longint us, input longint hz);
    longint cyc;
    cyc = (us * hz) / 64'sd1000000;
    return int'(cyc);
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for the PS/2 clock and data lines plus a falling-edge pulse on clock.
module ps2_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk_in,
  input  logic ps2_data_in,
  output logic clk_sync,
  output logic data_sync,
  output logic clk_fall
);

  logic [1:0] clk_ff;
  logic [1:0] data_ff;
  logic       clk_prev;

  // Reset to the idle-high bus level so leaving reset never fakes an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_ff   <= 2'b11;
      data_ff  <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_ff   <= {clk_ff[0], ps2_clk_in};
      data_ff  <= {data_ff[0], ps2_data_in};
      clk_prev <= clk_ff[1];
    end
  end

  assign clk_sync  = clk_ff[1];
  assign data_sync = data_ff[1];
  assign clk_fall  = clk_prev & ~clk_ff[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, ten data-side bits,
// device ACK check and bus-idle wait, with an overall timeout guarding the device phase.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 4000000,
  parameter int INHIBIT_US = 100,
  parameter int TIMEOUT_US = 15000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic [2:0] state_dbg
);

  localparam int INHIBIT_CYC = us2cyc(longint'(INHIBIT_US), longint'(CLK_HZ));
  localparam int TIMEOUT_CYC = us2cyc(longint'(TIMEOUT_US), longint'(CLK_HZ));
  localparam int TW          = $clog2(TIMEOUT_CYC + 1);

  localparam logic [TW-1:0] INHIBIT_LAST = TW'(INHIBIT_CYC - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] TIMER_MAX    = {TW{1'b1}};

  logic [2:0]            state;
  logic [FRAME_BITS-1:0] shift;
  logic [3:0]            bitcnt;
  logic [TW-1:0]         timer;
  logic [TW-1:0]         timer_inc;
  logic                  timeout_hit;
  logic                  clk_s;
  logic                  data_s;
  logic                  clk_fall;

  ps2_line_sync u_sync (
    .clk         (clk),
    .reset       (reset),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .clk_sync    (clk_s),
    .data_sync   (data_s),
    .clk_fall    (clk_fall)
  );

  assign timer_inc   = (timer == TIMER_MAX) ? timer : timer + 1'b1;
  assign timeout_hit = (timer == TIMEOUT_LAST);

  // Request handshake: tx_start is a one-cycle strobe honoured only while tx_busy is low
  // (IDLE); strobes at any other time are dropped, never queued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      shift       <= '0;
      bitcnt      <= '0;
      timer       <= '0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (tx_start) begin
            shift      <= {1'b1, ~^tx_data, tx_data};
            ps2_clk_oe <= 1'b1;
            timer      <= '0;
            state      <= ST_INHIBIT;
          end
        end
        ST_INHIBIT: begin
          if (timer == INHIBIT_LAST) begin
            ps2_data_oe <= 1'b1;
            timer       <= '0;
            state       <= ST_REQ;
          end else begin
            timer <= timer_inc;
          end
        end
        ST_REQ: begin
          ps2_clk_oe <= 1'b0;
          timer      <= '0;
          bitcnt     <= '0;
          state      <= ST_BITS;
        end
        ST_BITS, ST_ACK, ST_WAITIDLE: begin
          // Timeout is checked first so it beats a clock fall in the same cycle.
          if (timeout_hit) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            state       <= ST_ERROR;
          end else begin
            timer <= timer_inc;
            if (state == ST_BITS && clk_fall) begin
              ps2_data_oe <= ~shift[0];
              shift       <= shift >> 1;
              bitcnt      <= bitcnt + 4'd1;
              if (bitcnt == 4'(FRAME_BITS - 1)) state <= ST_ACK;
            end else if (state == ST_ACK && clk_fall) begin
              bitcnt <= 4'(ACK_FALL);
              state  <= data_s ? ST_ERROR : ST_WAITIDLE;
            end else if (state == ST_WAITIDLE && clk_s && data_s) begin
              state <= ST_DONE;
            end
          end
        end
        ST_DONE:  state <= ST_IDLE;
        ST_ERROR: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          state       <= ST_IDLE;
        end
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign tx_busy   = (state != ST_IDLE);
  assign tx_done   = (state == ST_DONE);
  assign tx_error  = (state == ST_ERROR);
  assign state_dbg = state;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a behavioural PS/2 keyboard on the open-drain lines.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int HALF = 120;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       tx_busy, tx_done, tx_error;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       ps2_clk_in, ps2_data_in;
  logic [2:0] state_dbg;
  logic       dev_clk = 1'b1;
  logic       dev_data_low = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  logic [10:0] exp_q[$];

  int   done_cnt = 0;
  int   err_cnt = 0;
  int   busy_bad = 0;
  logic prev_done = 1'b0;

  // clock / reset
  always #125 clk = ~clk;

  assign ps2_clk_in  = ~(ps2_clk_oe | ~dev_clk);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx dut (
    .clk         (clk),
    .reset       (reset),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .tx_error    (tx_error),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .state_dbg   (state_dbg)
  );

  // pulse monitor: done must be a single cycle with busy high, and busy drops as it ends
  always @(negedge clk) begin
    prev_done <= tx_done;
    if (tx_done) done_cnt <= done_cnt + 1;
    if (tx_error) err_cnt <= err_cnt + 1;
    if ((tx_done && !tx_busy) || (prev_done && (tx_done || tx_busy))) busy_bad <= busy_bad + 1;
  end

  function automatic logic [10:0] frame_of(input logic [7:0] d);
    return {1'b1, ~^d, d, 1'b0};
  endfunction

  // driver tasks
  task automatic send_start(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  // keyboard: waits for request-to-send, reads start, clocks 10 bits, then the ACK clock
  task automatic device_frame(input bit ack_low, output logic [10:0] seen, output bit timed_out);
    int n;
    n = 0;
    seen = '0;
    timed_out = 1'b0;
    while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      timed_out = 1'b1;
      return;
    end
    repeat (40) @(negedge clk);
    seen[0] = ps2_data_in;
    for (int i = 1; i <= 10; i++) begin
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      @(negedge clk);
      seen[i] = ps2_data_in;
      repeat (HALF - 1) @(negedge clk);
    end
    if (ack_low) dev_data_low = 1'b1;
    repeat (20) @(negedge clk);
    dev_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    dev_clk = 1'b1;
    repeat (20) @(negedge clk);
    dev_data_low = 1'b0;
  endtask

  task automatic wait_done(output bit got);
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (tx_done) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if ({tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_data_oe} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b required 00000",
               {tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_data_oe});
    end
    reset = 1'b0;
    repeat (5) @(negedge clk);
    vectors++;
    if ({tx_busy, ps2_clk_oe, ps2_data_oe} !== 3'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: got %b required 000", {tx_busy, ps2_clk_oe, ps2_data_oe});
    end
  endtask

  task automatic test_frame_ed();
    logic [10:0] seen, exp;
    bit to, got;
    int inh, d0;
    d0 = done_cnt;
    exp_q.push_back(frame_of(8'hED));
    send_start(8'hED);
    vectors++;
    if (tx_busy !== 1'b1 || ps2_clk_oe !== 1'b1) begin
      miscompares++;
      $display("FAIL accept: busy=%b clk_oe=%b required 1 1", tx_busy, ps2_clk_oe);
    end
    inh = 0;
    while (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b0 && inh < 1000) begin
      inh++;
      @(negedge clk);
    end
    vectors++;
    if (inh != 400) begin
      miscompares++;
      $display("FAIL inhibit_len: got %0d cycles required 400", inh);
    end
    vectors++;
    if ({ps2_clk_oe, ps2_data_oe} !== 2'b11) begin
      miscompares++;
      $display("FAIL req_lines: got %b required 11", {ps2_clk_oe, ps2_data_oe});
    end
    @(negedge clk);
    vectors++;
    if ({ps2_clk_oe, ps2_data_oe} !== 2'b01) begin
      miscompares++;
      $display("FAIL clk_release: got %b required 01", {ps2_clk_oe, ps2_data_oe});
    end
    device_frame(1'b1, seen, to);
    exp = exp_q.pop_front();
    vectors++;
    if (to || seen !== exp) begin
      miscompares++;
      $display("FAIL frame_ed: got %b (timeout %0d) required %b", seen, to, exp);
    end
    wait_done(got);
    repeat (5) @(negedge clk);
    vectors++;
    if (!got || done_cnt - d0 != 1 || busy_bad != 0 || tx_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL done_ed: seen %0d pulses=%0d busy_bad=%0d busy=%b required 1 1 0 0",
               got, done_cnt - d0, busy_bad, tx_busy);
    end
  endtask

  task automatic test_parity();
    logic [7:0] vals[3];
    logic       par_req[3];
    logic [10:0] seen, exp;
    bit to, got;
    vals    = '{8'h00, 8'hFF, 8'h01};
    par_req = '{1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(frame_of(vals[k]));
      send_start(vals[k]);
      device_frame(1'b1, seen, to);
      exp = exp_q.pop_front();
      vectors++;
      if (to || seen !== exp) begin
        miscompares++;
        $display("FAIL frame_%h: got %b required %b", vals[k], seen, exp);
      end
      vectors++;
      if (seen[9] !== par_req[k]) begin
        miscompares++;
        $display("FAIL parity_%h: got %b required %b", vals[k], seen[9], par_req[k]);
      end
      wait_done(got);
      vectors++;
      if (!got) begin
        miscompares++;
        $display("FAIL done_%h: got no done pulse required one", vals[k]);
      end
    end
  endtask

  task automatic test_timeout();
    int n, cnt;
    bit saw_done;
    send_start(8'h42);
    n = 0;
    while (ps2_clk_oe === 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    cnt = 0;
    saw_done = 1'b0;
    while (tx_error !== 1'b1 && cnt < 61000) begin
      @(negedge clk);
      cnt++;
      if (tx_done) saw_done = 1'b1;
    end
    vectors++;
    if (cnt != 60000) begin
      miscompares++;
      $display("FAIL timeout_len: got %0d cycles required 60000", cnt);
    end
    vectors++;
    if ({ps2_clk_oe, ps2_data_oe} !== 2'b00 || saw_done) begin
      miscompares++;
      $display("FAIL timeout_lines: oe=%b done=%0d required 00 0", {ps2_clk_oe, ps2_data_oe}, saw_done);
    end
    @(negedge clk);
    vectors++;
    if (tx_error !== 1'b0 || tx_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_exit: error=%b busy=%b required 0 0", tx_error, tx_busy);
    end
  endtask

  task automatic test_nack();
    logic [10:0] seen, exp;
    bit to;
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    exp_q.push_back(frame_of(8'h5A));
    send_start(8'h5A);
    device_frame(1'b0, seen, to);
    exp = exp_q.pop_front();
    vectors++;
    if (to || seen !== exp) begin
      miscompares++;
      $display("FAIL frame_5a: got %b required %b", seen, exp);
    end
    repeat (20) @(negedge clk);
    vectors++;
    if (err_cnt - e0 != 1 || done_cnt - d0 != 0) begin
      miscompares++;
      $display("FAIL nack_pulses: errors=%0d dones=%0d required 1 0", err_cnt - e0, done_cnt - d0);
    end
    vectors++;
    if ({tx_busy, ps2_clk_oe, ps2_data_oe} !== 3'b000) begin
      miscompares++;
      $display("FAIL nack_idle: got %b required 000", {tx_busy, ps2_clk_oe, ps2_data_oe});
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] seen, exp;
    bit to, got;
    int d0, viol;
    d0 = done_cnt;
    exp_q.push_back(frame_of(8'h3C));
    send_start(8'h3C);
    fork
      device_frame(1'b1, seen, to);
      begin
        repeat (200) @(negedge clk);
        tx_data = 8'hAA; tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (800) @(negedge clk);
        tx_data = 8'h55; tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
      end
    join
    exp = exp_q.pop_front();
    vectors++;
    if (to || seen !== exp) begin
      miscompares++;
      $display("FAIL frame_3c: got %b required %b", seen, exp);
    end
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (tx_done) begin
        got = 1'b1;
        tx_data = 8'h81;
        tx_start = 1'b1;
      end
    end
    @(negedge clk);
    tx_start = 1'b0;
    viol = 0;
    repeat (300) begin
      @(negedge clk);
      if (tx_busy || ps2_clk_oe || ps2_data_oe) viol++;
    end
    vectors++;
    if (!got || viol != 0 || done_cnt - d0 != 1) begin
      miscompares++;
      $display("FAIL no_requeue: done_seen=%0d busy_cycles=%0d dones=%0d required 1 0 1",
               got, viol, done_cnt - d0);
    end
    send_start(8'h96);
    vectors++;
    if ({tx_busy, ps2_clk_oe, ps2_data_oe} !== 3'b110) begin
      miscompares++;
      $display("FAIL restart_inhibit: got %b required 110", {tx_busy, ps2_clk_oe, ps2_data_oe});
    end
  endtask

  // continues the 0x96 frame started above and resets while d5 (a 0) is on the bus
  task automatic test_reset_mid_frame();
    logic [10:0] seen, exp;
    bit to, got;
    int n, d0, e0;
    n = 0;
    while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (40) @(negedge clk);
    for (int i = 1; i <= 5; i++) begin
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    dev_clk = 1'b0;
    repeat (20) @(negedge clk);
    vectors++;
    if (n >= 2000 || ps2_data_oe !== 1'b1 || tx_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL bit5_driven: data_oe=%b busy=%b required 1 1", ps2_data_oe, tx_busy);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if ({ps2_clk_oe, ps2_data_oe, tx_busy} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_release: got %b required 000", {ps2_clk_oe, ps2_data_oe, tx_busy});
    end
    repeat (HALF) @(negedge clk);
    dev_clk = 1'b1;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    d0 = done_cnt;
    e0 = err_cnt;
    exp_q.push_back(frame_of(8'hF4));
    send_start(8'hF4);
    device_frame(1'b1, seen, to);
    exp = exp_q.pop_front();
    vectors++;
    if (to || seen !== exp) begin
      miscompares++;
      $display("FAIL frame_f4: got %b required %b", seen, exp);
    end
    wait_done(got);
    repeat (5) @(negedge clk);
    vectors++;
    if (!got || done_cnt - d0 != 1 || err_cnt - e0 != 0) begin
      miscompares++;
      $display("FAIL done_f4: seen %0d dones=%0d errors=%0d required 1 1 0",
               got, done_cnt - d0, err_cnt - e0);
    end
  endtask

  initial begin
    test_reset();
    test_frame_ed();
    test_parity();
    test_timeout();
    test_nack();
    test_back_to_back();
    test_reset_mid_frame();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d frames left required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
